// File: rtl/onehot_ring_fsm_if.sv
// Bundle between a one-hot ring sequencer and the controller that steers it.
// The master side drives the advance/hold/jump requests; the slave side reports state.
interface onehot_ring_fsm_if #(
    parameter int NUM_ST  = 3,
    parameter int IDX_W   = 2,
    parameter int DWELL_W = 4
);
    logic [NUM_ST-1:0]  go;
    logic               hold;
    logic               jump_valid;
    logic [IDX_W-1:0]   jump_idx;
    logic [NUM_ST-1:0]  st;
    logic [IDX_W-1:0]   st_idx;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               wrapped;
    logic               err;

    modport master (
        output go, hold, jump_valid, jump_idx,
        input  st, st_idx, dwell_cnt, wrapped, err
    );

    modport slave (
        input  go, hold, jump_valid, jump_idx,
        output st, st_idx, dwell_cnt, wrapped, err
    );
endinterface

// File: rtl/onehot_ring_fsm.sv
// Parametrised one-hot ring sequencer with minimum-dwell gating, hold, direct jump,
// wrap pulse and recovery from illegal (non one-hot) state encodings.
module onehot_ring_fsm #(
    parameter int NUM_ST    = 3,
    parameter int IDX_W     = 2,
    parameter int DWELL_W   = 4,
    parameter int MIN_DWELL = 0
) (
    input  logic              clock,
    input  logic              reset,
    onehot_ring_fsm_if.slave  bus
);
    localparam logic [IDX_W:0]     NUM_ST_W    = (IDX_W+1)'(NUM_ST);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_ST - 1);
    localparam logic [DWELL_W-1:0] MIN_DWELL_V = DWELL_W'(MIN_DWELL);
    localparam logic [DWELL_W-1:0] DWELL_MAX   = '1;

    logic [NUM_ST-1:0]  st_q, st_d;
    logic [IDX_W-1:0]   st_idx_q, st_idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               wrapped_q, wrapped_d;
    logic               err_q, err_d;

    logic st_legal;
    logic jump_ok;
    logic go_hit;
    logic dwell_ok;

    assign st_legal = (st_q != '0) && ((st_q & (st_q - 1'b1)) == '0);
    assign jump_ok  = {1'b0, bus.jump_idx} < NUM_ST_W;
    assign go_hit   = |(bus.go & st_q);

    // A zero minimum dwell would make the comparison trivially true, so it is elided.
    generate
        if (MIN_DWELL == 0) begin : g_no_dwell
            assign dwell_ok = 1'b1;
        end else begin : g_dwell
            assign dwell_ok = dwell_q >= MIN_DWELL_V;
        end
    endgenerate

    always_comb begin
        st_d      = st_q;
        st_idx_d  = st_idx_q;
        dwell_d   = dwell_q;
        wrapped_d = 1'b0;
        err_d     = 1'b0;
        if (!st_legal) begin
            st_d     = NUM_ST'(1);
            st_idx_d = '0;
            dwell_d  = '0;
            err_d    = 1'b1;
        end else if (bus.jump_valid && jump_ok) begin
            st_d     = NUM_ST'(1) << bus.jump_idx;
            st_idx_d = bus.jump_idx;
            dwell_d  = '0;
        end else begin
            // An out-of-range jump is flagged but otherwise falls through to normal sequencing.
            err_d = bus.jump_valid;
            if (bus.hold) begin
                st_d = st_q;
            end else if (go_hit && dwell_ok) begin
                if (NUM_ST > 1) begin
                    st_d = {st_q[NUM_ST-2:0], st_q[NUM_ST-1]};
                end
                st_idx_d  = (st_idx_q == LAST_IDX) ? '0 : st_idx_q + 1'b1;
                dwell_d   = '0;
                wrapped_d = st_q[NUM_ST-1];
            end else if (dwell_q != DWELL_MAX) begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q      <= NUM_ST'(1);
            st_idx_q  <= '0;
            dwell_q   <= '0;
            wrapped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            st_idx_q  <= st_idx_d;
            dwell_q   <= dwell_d;
            wrapped_q <= wrapped_d;
            err_q     <= err_d;
        end
    end

    assign bus.st        = st_q;
    assign bus.st_idx    = st_idx_q;
    assign bus.dwell_cnt = dwell_q;
    assign bus.wrapped   = wrapped_q;
    assign bus.err       = err_q;
endmodule
